reg_transfer_sequencer: RTL and testbench
=========================================

Name: reg_transfer_sequencer

Overview:
- Fetch/decode/execute controller for the shared-bus register datapath.
- Each cycle it drives one destination register code `wr_addr`, which feeds the one-hot register write decoder, and one bus source select `bus_sel`.
- It also drives the ALU operation and a request/acknowledge memory handshake.
- It sits between the IR contents and the register-enable decoder, and it is the only writer of `wr_addr`.

Parameters:
- MEM_TIMEOUT, 255: max cycles waiting for `mem_ack` before entering ERR. 0 disables the timeout.
- CNT_W, 8: width of the wait counter. Must satisfy MEM_TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin/resume execution; sampled in IDLE and HALT only
- ir_word  in  8  IR contents: [7:4] opcode, [3:0] register operand
- z_flag  in  1  AC==0 flag from ALU, sampled in EX1 of JMPZ
- mem_ack  in  1  one-cycle memory completion strobe
- wr_addr  out  4  destination register code: 1=H,2=W,3=K,4=COUNT,5=X,6=J,7=L,8=CENTERP,9=T,10=AC,11=PC,12=MDR,13=MAR,14=IR; 0=no write
- bus_sel  out  4  bus source, same codes; 15=memory read data; 0=bus idle
- alu_op  out  2  00 pass bus, 01 AC+bus, 10 AC-bus
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write qualifier, valid while mem_req=1
- pc_inc  out  1  PC increment strobe
- busy  out  1  high in every state except IDLE, HALT, ERR
- done  out  1  high in HALT
- error  out  1  high in ERR

Behaviour:
- Reset: asynchronous to IDLE. All outputs 0. Wait counter 0. A reset mid-instruction or mid-handshake drops `mem_req` immediately; no partial write completes.
- States: IDLE, F1, F2, F3, DEC, EX1, EXW, HALT, ERR. All outputs are decoded from state, except the ack-cycle writes noted below.
- IDLE: `start`=1 -> F1.
- F1: `bus_sel`=PC(11), `wr_addr`=MAR(13). Next state F2.
- F2: `mem_req`=1, `mem_we`=0. The wait counter increments each cycle.
  - In the cycle `mem_ack`=1: `bus_sel`=15 and `wr_addr`=MDR(12), then go to F3.
  - A zero-wait memory acks in the first F2 cycle.
- F3: `bus_sel`=MDR, `wr_addr`=IR(14), `pc_inc`=1. Next state DEC.
- DEC: no outputs. Latches `ir_word`.
  - Legal instruction -> EX1.
  - Illegal opcode, or operand 0 or 15 on a register-operand instruction -> ERR.
- Opcodes and their EX1 action (r = operand):
  - 0 NOP: nothing.
  - 1 LDAC r: `bus_sel`=r, `alu_op`=00, `wr_addr`=AC.
  - 2 STAC r: `bus_sel`=AC, `wr_addr`=r.
  - 3 ADD r: `bus_sel`=r, `alu_op`=01, `wr_addr`=AC.
  - 4 SUB r: `bus_sel`=r, `alu_op`=10, `wr_addr`=AC.
  - 5 LOAD: go to EXW with `mem_we`=0. On ack, `bus_sel`=15 and `wr_addr`=MDR.
  - 6 STORE: go to EXW with `mem_we`=1 and `bus_sel`=MDR throughout. No register write on ack.
  - 7 JMP: `bus_sel`=MDR, `wr_addr`=PC.
  - 8 JMPZ: as JMP if `z_flag`=1; otherwise no write.
  - 9 MVMAR r: `bus_sel`=r, `wr_addr`=MAR.
  - F HALT: go to HALT.
  - Opcodes A–E are illegal.
- After EX1, or after EXW on ack, the next state is F1. A non-memory instruction therefore takes 5 cycles with zero-wait memory; LOAD/STORE take 6.
- Wait counter: cleared on entry to F2 and EXW. If the counter reaches MEM_TIMEOUT with no ack: `mem_req` drops and the next state is ERR.
  - An ack arriving in the same cycle the timeout is reached wins.
  - `mem_ack` outside F2/EXW is ignored.
- HALT: `done`=1. `start`=1 -> F1, resuming from the current PC.
- ERR: `error`=1 until `rst_n` is asserted; `start` is ignored.
- Invariants:
  - `wr_addr` is never 15.
  - `wr_addr` is never equal to `bus_sel` in the same cycle.
  - `mem_req` is high only in F2/EXW.
  - `pc_inc` is high only in F3.

Test Plan:
1. Reset, `start`=1, memory acks in the first request cycle, `ir_word`=0x1A (LDAC AC): F1 drives `wr_addr`=13/`bus_sel`=11 → ack cycle drives 12/15 → F3 drives 14/12 with `pc_inc` → EX1 drives `wr_addr`=10. Next F1 occurs 5 cycles after the first F1.
2. `ir_word`=0x35 (ADD X) with ack delayed 3 cycles: `mem_req` stays high 4 cycles and drops the cycle after ack. EX1 shows `bus_sel`=5, `alu_op`=01, `wr_addr`=10.
3. `ir_word`=0x60 (STORE) with ack after 2 cycles: EXW holds `mem_req`=1, `mem_we`=1, `bus_sel`=12 for 3 cycles; `wr_addr`=0 throughout EXW.
4. `ir_word`=0x80 (JMPZ) with `z_flag`=0, then repeated with `z_flag`=1: the first gives `wr_addr`=0 in EX1; the second gives `wr_addr`=11 with `bus_sel`=12.
5. Illegal `ir_word`=0xB3, and separately `ir_word`=0x20 (STAC with operand 0): DEC → ERR, `error`=1, `busy`=0. A following `start` has no effect until `rst_n` pulses low.
6. MEM_TIMEOUT=4 with no ack: `mem_req` is high 4 cycles, then ERR. Separately, `rst_n` asserted low mid-F2: all outputs are 0 immediately and the state is IDLE.

Source files
------------

// File: rtl/reg_transfer_sequencer.sv
// Fetch/decode/execute sequencer for the shared-bus register datapath.
// Drives register write code, bus source, ALU op and memory handshake.
module reg_transfer_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] ir_word,
  input  logic       z_flag,
  input  logic       mem_ack,
  output logic [3:0] wr_addr,
  output logic [3:0] bus_sel,
  output logic [1:0] alu_op,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_inc,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_F3,
    S_DEC,
    S_EX1,
    S_EXW,
    S_HALT,
    S_ERR
  } state_t;

  localparam logic [3:0] R_AC  = 4'd10;
  localparam logic [3:0] R_PC  = 4'd11;
  localparam logic [3:0] R_MDR = 4'd12;
  localparam logic [3:0] R_MAR = 4'd13;
  localparam logic [3:0] R_IR  = 4'd14;
  localparam logic [3:0] R_MEM = 4'd15;

  localparam logic [3:0] OP_LDAC  = 4'h1;
  localparam logic [3:0] OP_STAC  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JMPZ  = 4'h8;
  localparam logic [3:0] OP_MVMAR = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Last counter value before the timeout fires; unused when disabled.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state;
  logic [7:0]       ir_q;
  logic [CNT_W-1:0] wait_cnt;

  logic [3:0] opc;
  logic [3:0] opr;
  logic       reg_op;
  logic       bad_op;
  logic       bad_reg;
  logic       dec_legal;
  logic       timed_out;
  logic [3:0] wr_raw;
  logic [3:0] bus_raw;

  assign opc = ir_q[7:4];
  assign opr = ir_q[3:0];

  assign reg_op = ir_word[7:4] inside
    {OP_LDAC, OP_STAC, OP_ADD, OP_SUB, OP_MVMAR};
  assign bad_op = ir_word[7:4] inside {[4'hA:4'hE]};
  assign bad_reg = reg_op &&
    (ir_word[3:0] == 4'd0 || ir_word[3:0] == 4'd15);
  assign dec_legal = !(bad_op || bad_reg);

  // An ack in the final wait cycle is checked first, so it wins.
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);

  // Sequencer state, latched instruction and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir_q     <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_F1;
        S_F1: begin
          state    <= S_F2;
          wait_cnt <= '0;
        end
        S_F2: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (mem_ack)        state <= S_F3;
          else if (timed_out) state <= S_ERR;
        end
        S_F3: state <= S_DEC;
        S_DEC: begin
          ir_q  <= ir_word;
          state <= dec_legal ? S_EX1 : S_ERR;
        end
        S_EX1: begin
          case (opc)
            OP_LOAD, OP_STORE: begin
              state    <= S_EXW;
              wait_cnt <= '0;
            end
            OP_HALT: state <= S_HALT;
            default: state <= S_F1;
          endcase
        end
        S_EXW: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (mem_ack)        state <= S_F1;
          else if (timed_out) state <= S_ERR;
        end
        S_HALT: if (start) state <= S_F1;
        S_ERR: state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from state, plus the ack-cycle MDR capture.
  always_comb begin
    wr_raw  = '0;
    bus_raw = '0;
    alu_op  = 2'b00;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    pc_inc  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    case (state)
      S_F1: begin
        busy    = 1'b1;
        bus_raw = R_PC;
        wr_raw  = R_MAR;
      end
      S_F2: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          bus_raw = R_MEM;
          wr_raw  = R_MDR;
        end
      end
      S_F3: begin
        busy    = 1'b1;
        pc_inc  = 1'b1;
        bus_raw = R_MDR;
        wr_raw  = R_IR;
      end
      S_DEC: busy = 1'b1;
      S_EX1: begin
        busy = 1'b1;
        case (opc)
          OP_LDAC: begin
            bus_raw = opr;
            wr_raw  = R_AC;
          end
          OP_STAC: begin
            bus_raw = R_AC;
            wr_raw  = opr;
          end
          OP_ADD: begin
            bus_raw = opr;
            alu_op  = 2'b01;
            wr_raw  = R_AC;
          end
          OP_SUB: begin
            bus_raw = opr;
            alu_op  = 2'b10;
            wr_raw  = R_AC;
          end
          OP_JMP: begin
            bus_raw = R_MDR;
            wr_raw  = R_PC;
          end
          OP_JMPZ: begin
            if (z_flag) begin
              bus_raw = R_MDR;
              wr_raw  = R_PC;
            end
          end
          OP_MVMAR: begin
            bus_raw = opr;
            wr_raw  = R_MAR;
          end
          default: ;
        endcase
      end
      S_EXW: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (opc == OP_STORE) begin
          mem_we  = 1'b1;
          bus_raw = R_MDR;
        end else if (mem_ack) begin
          bus_raw = R_MEM;
          wr_raw  = R_MDR;
        end
      end
      S_HALT: done  = 1'b1;
      S_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  // A register never sources the bus in the cycle it is written.
  assign wr_addr = wr_raw;
  assign bus_sel =
    (wr_raw != 4'd0 && bus_raw == wr_raw) ? 4'd0 : bus_raw;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Randomized bench for reg_transfer_sequencer.
// Expected per-cycle trace is built from instruction-level rules.
module tb_reg_transfer_sequencer;

  localparam int TO = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] ir_word;
  logic       z_flag;
  logic       mem_ack;
  logic [3:0] wr_addr;
  logic [3:0] bus_sel;
  logic [1:0] alu_op;
  logic       mem_req;
  logic       mem_we;
  logic       pc_inc;
  logic       busy;
  logic       done;
  logic       error;

  reg_transfer_sequencer #(
    .MEM_TIMEOUT(TO),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ir_word(ir_word),
    .z_flag(z_flag),
    .mem_ack(mem_ack),
    .wr_addr(wr_addr),
    .bus_sel(bus_sel),
    .alu_op(alu_op),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .pc_inc(pc_inc),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {mem_req, mem_we, pc_inc, busy, done, error}
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_BUSY  = 6'b000100;
  localparam logic [5:0] F_REQ   = 6'b100100;
  localparam logic [5:0] F_REQWE = 6'b110100;
  localparam logic [5:0] F_PINC  = 6'b001100;
  localparam logic [5:0] F_DONE  = 6'b000010;
  localparam logic [5:0] F_ERR   = 6'b000001;

  typedef struct packed {
    logic       st;
    logic       ack;
    logic       z;
    logic [7:0] ir;
    logic [3:0] wr;
    logic [3:0] bus;
    logic [1:0] alu;
    logic [5:0] fl;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   cyc_no;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               tag, cyc_no, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] junk();
    return 8'($urandom);
  endfunction

  task automatic push(input logic st, input logic ack,
                      input logic z, input logic [7:0] ir,
                      input logic [3:0] wr, input logic [3:0] bus,
                      input logic [1:0] alu, input logic [5:0] fl);
    exp_t e;
    e.st  = st;
    e.ack = ack;
    e.z   = z;
    e.ir  = ir;
    e.wr  = wr;
    e.bus = (wr != 4'd0 && bus == wr) ? 4'd0 : bus;
    e.alu = alu;
    e.fl  = fl;
    q.push_back(e);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++)
      push(i == n - 1, rb(), rb(), junk(), 0, 0, 0, F_NONE);
  endtask

  task automatic add_err(input int n);
    for (int i = 0; i < n; i++)
      push(rb(), rb(), rb(), junk(), 0, 0, 0, F_ERR);
  endtask

  task automatic add_halt(input int n);
    for (int i = 0; i < n; i++)
      push(0, rb(), rb(), junk(), 0, 0, 0, F_DONE);
    push(1, rb(), rb(), junk(), 0, 0, 0, F_DONE);
  endtask

  // d = idle cycles before ack; d >= TO means the memory never answers.
  task automatic add_wait(input int d, input logic store,
                          output logic ok);
    int n;
    n = (d < TO) ? d : TO;
    for (int i = 0; i < n; i++)
      push(0, 0, rb(), junk(), 0, store ? 4'd12 : 4'd0, 0,
           store ? F_REQWE : F_REQ);
    ok = (d < TO);
    if (ok)
      push(0, 1, rb(), junk(),
           store ? 4'd0 : 4'd12, store ? 4'd12 : 4'd15, 0,
           store ? F_REQWE : F_REQ);
  endtask

  // fin: 0 = next instruction follows, 1 = halted, 2 = error
  task automatic add_instr(input logic [7:0] ir, input int df,
                           input int de, input logic z,
                           output int fin);
    logic [3:0] op;
    logic [3:0] r;
    logic       ok;
    logic       legal;
    logic [3:0] wr;
    logic [3:0] bus;
    logic [1:0] alu;
    op  = ir[7:4];
    r   = ir[3:0];
    fin = 0;
    push(0, rb(), rb(), junk(), 13, 11, 0, F_BUSY);
    add_wait(df, 0, ok);
    if (!ok) begin
      fin = 2;
      return;
    end
    push(0, rb(), rb(), junk(), 14, 12, 0, F_PINC);
    push(0, rb(), rb(), ir, 0, 0, 0, F_BUSY);
    legal = !(op >= 4'hA && op <= 4'hE);
    if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h9})
      if (r == 4'd0 || r == 4'd15) legal = 1'b0;
    if (!legal) begin
      fin = 2;
      return;
    end
    wr  = 0;
    bus = 0;
    alu = 0;
    case (op)
      4'h1: begin bus = r;  wr = 10; end
      4'h2: begin bus = 10; wr = r;  end
      4'h3: begin bus = r;  wr = 10; alu = 1; end
      4'h4: begin bus = r;  wr = 10; alu = 2; end
      4'h7: begin bus = 12; wr = 11; end
      4'h8: if (z) begin bus = 12; wr = 11; end
      4'h9: begin bus = r;  wr = 13; end
      default: ;
    endcase
    push(0, rb(), z, junk(), wr, bus, alu, F_BUSY);
    if (op == 4'h5 || op == 4'h6) begin
      add_wait(de, op == 4'h6, ok);
      fin = ok ? 0 : 2;
    end else if (op == 4'hF) begin
      fin = 1;
    end
  endtask

  function automatic logic [7:0] rand_instr();
    logic [3:0] op;
    logic [3:0] r;
    op = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) op = 4'hF;
    r = 4'($urandom_range(1, 14));
    if (!(op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h9}))
      r = 4'($urandom);
    return {op, r};
  endfunction

  task automatic play();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      start   = e.st;
      mem_ack = e.ack;
      z_flag  = e.z;
      ir_word = e.ir;
      @(negedge clk);
      chk("wr_addr", 16'(wr_addr), 16'(e.wr));
      chk("bus_sel", 16'(bus_sel), 16'(e.bus));
      chk("alu_op", 16'(alu_op), 16'(e.alu));
      chk("flags",
          16'({mem_req, mem_we, pc_inc, busy, done, error}),
          16'(e.fl));
      chk("inv_wr15", 16'(wr_addr == 4'd15), 16'd0);
      chk("inv_loop",
          16'(wr_addr != 4'd0 && wr_addr == bus_sel), 16'd0);
      cyc_no++;
      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {wr_addr, bus_sel, alu_op, mem_req, mem_we,
              pc_inc, busy, done, error}, 16'd0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fin;
    logic [7:0] ir;
    n_chk   = 0;
    n_fail  = 0;
    cyc_no  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    mem_ack = 1'b0;
    z_flag  = 1'b0;
    ir_word = 8'h00;
    #1 chk_zero("por_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    add_idle(2);
    add_instr(8'h1A, 0, 0, rb(), fin);
    add_instr(8'h35, 3, 0, rb(), fin);
    add_instr(8'h60, 0, 2, rb(), fin);
    add_instr(8'h80, 0, 0, 1'b0, fin);
    add_instr(8'h80, 0, 0, 1'b1, fin);
    add_instr(8'h57, 1, 3, rb(), fin);
    add_instr(8'h2A, 0, 0, rb(), fin);
    add_instr(8'h9D, 0, 0, rb(), fin);
    add_instr(8'hF0, 0, 0, rb(), fin);
    add_halt(2);
    for (int i = 0; i < 60; i++) begin
      ir = rand_instr();
      add_instr(ir, $urandom_range(0, 3), $urandom_range(0, 3),
                rb(), fin);
      if (fin == 1) add_halt($urandom_range(0, 2));
    end
    add_instr(8'h53, 0, TO, rb(), fin);
    add_err(3);
    play();

    do_reset();
    add_idle(1);
    add_instr(8'hB3, 0, 0, rb(), fin);
    add_err(4);
    play();

    do_reset();
    add_idle(1);
    add_instr(8'h20, 1, 0, rb(), fin);
    add_err(3);
    play();

    do_reset();
    add_idle(1);
    add_instr(8'h00, TO, 0, rb(), fin);
    add_err(2);
    play();

    do_reset();
    add_idle(1);
    push(0, 0, 0, 8'h00, 13, 11, 0, F_BUSY);
    push(0, 0, 0, 8'h00, 0, 0, 0, F_REQ);
    push(0, 0, 0, 8'h00, 0, 0, 0, F_REQ);
    play();
    mem_ack = 1'b1;
    #1 chk("pre_rst_wr", 16'(wr_addr), 16'd12);
    #1 rst_n = 1'b0;
    #1 chk_zero("mid_f2_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    add_idle(2);
    add_instr(8'h1A, 0, 0, rb(), fin);
    add_instr(8'h44, 2, 0, rb(), fin);
    play();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
